// File: rtl/synth_disp_pkg.sv
// synth_disp_pkg: shared types for the mode banner display.
//  - char_t    : 5-bit character code (0-9 numeric, letter subset, dash, blank)
//  - state_t   : display sequencer states
//  - banner_char(mode, idx): per-mode banner text ROM, 8 characters per mode
package synth_disp_pkg;

   typedef logic [4:0] char_t;

   // Codes 0..9 are the decimal digits themselves.
   localparam char_t C_A     = 5'd10;
   localparam char_t C_E     = 5'd11;
   localparam char_t C_G     = 5'd12;
   localparam char_t C_I     = 5'd13;
   localparam char_t C_L     = 5'd14;
   localparam char_t C_N     = 5'd15;
   localparam char_t C_Q     = 5'd16;
   localparam char_t C_R     = 5'd17;
   localparam char_t C_S     = 5'd18;
   localparam char_t C_T     = 5'd19;
   localparam char_t C_U     = 5'd20;
   localparam char_t C_W     = 5'd21;
   localparam char_t C_DASH  = 5'd22;
   localparam char_t C_BLANK = 5'd31;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      ST_BLINK  = 2'd0,
      ST_SCROLL = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   // Banner text ROM. Indices past the 8 stored characters read as blank so a
   // longer MSG_LEN just pads with spaces.
   function automatic char_t banner_char(input int unsigned mode, input int unsigned idx);
      char_t s [8];
      case (mode)
         0:       s = '{C_S, C_Q, C_U, C_A, C_R, C_E, C_BLANK, C_BLANK};
         1:       s = '{C_S, C_A, C_W, C_BLANK, C_BLANK, C_BLANK, C_BLANK, C_BLANK};
         2:       s = '{C_T, C_R, C_I, C_A, C_N, C_G, C_L, C_E};
         3:       s = '{C_S, C_I, C_N, C_E, C_BLANK, C_BLANK, C_BLANK, C_BLANK};
         default: s = '{default: C_DASH};
      endcase
      if (idx < 8) return s[idx[2:0]];
      return C_BLANK;
   endfunction

endpackage

// File: rtl/char_to_seg.sv
// char_to_seg: combinational character-code to 7-segment decoder.
//  code : 5-bit character code (synth_disp_pkg::char_t)
//  seg  : active-low segments, bit order g..a (bit 0 = a, 0 = lit)
// Any code without a glyph decodes to blank.
module char_to_seg
   import synth_disp_pkg::*;
(
   input  char_t      code,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (code)
         5'd0:    seg = 7'h40;
         5'd1:    seg = 7'h79;
         5'd2:    seg = 7'h24;
         5'd3:    seg = 7'h30;
         5'd4:    seg = 7'h19;
         5'd5:    seg = 7'h12;
         5'd6:    seg = 7'h02;
         5'd7:    seg = 7'h78;
         5'd8:    seg = 7'h00;
         5'd9:    seg = 7'h10;
         C_A:     seg = 7'h08;
         C_E:     seg = 7'h06;
         C_G:     seg = 7'h42;
         C_I:     seg = 7'h4F;
         C_L:     seg = 7'h47;
         C_N:     seg = 7'h2B;
         C_Q:     seg = 7'h18;
         C_R:     seg = 7'h2F;
         C_S:     seg = 7'h12;
         C_T:     seg = 7'h07;
         C_U:     seg = 7'h41;
         C_W:     seg = 7'h55;
         C_DASH:  seg = 7'h3F;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/mode_banner_display.sv
// mode_banner_display: mode-name readout on a bank of active-low 7-segment digits.
// On a mode change the new name blinks, the full banner scrolls, then the first
// NUM_DIGITS characters are held until the next change.
//  clk      : system clock
//  reset_n  : asynchronous active-low reset
//  mode     : asynchronous mode select, synchronised internally
//  hex_seg  : digit d at [7d+6:7d], d=0 rightmost, g..a, 0 = lit (registered)
//  busy     : high while blinking or scrolling
// The sequencer state lives in 'state' (synth_disp_pkg::state_t).
module mode_banner_display
   import synth_disp_pkg::*;
#(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned MODE_W        = 2,
   parameter int unsigned MSG_LEN       = 8,
   parameter int unsigned TICK_DIV      = 12500000,
   parameter int unsigned BLINK_PHASES  = 6,
   parameter int unsigned SCROLL_PASSES = 1
)(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [MODE_W-1:0]       mode,
   output logic [NUM_DIGITS*7-1:0] hex_seg,
   output logic                    busy
);

   localparam int unsigned CNT_W  = (TICK_DIV > 1)      ? $clog2(TICK_DIV)          : 1;
   localparam int unsigned PH_W   = (BLINK_PHASES > 1)  ? $clog2(BLINK_PHASES)      : 1;
   localparam int unsigned OFF_W  = (MSG_LEN > 1)       ? $clog2(MSG_LEN)           : 1;
   localparam int unsigned PASS_W = (SCROLL_PASSES > 1) ? $clog2(SCROLL_PASSES)     : 1;

   logic [MODE_W-1:0]       mode_meta, mode_sync, cur_mode;
   logic                    change, tick, blank_now;
   logic [CNT_W-1:0]        tick_cnt;
   logic [PH_W-1:0]         phase;
   logic [OFF_W-1:0]        offset;
   logic [PASS_W-1:0]       pass;
   state_t                  state;
   logic [NUM_DIGITS*7-1:0] seg_next;

   // Two-flop synchroniser for the switch inputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_meta <= '0;
         mode_sync <= '0;
      end else begin
         mode_meta <= mode;
         mode_sync <= mode_meta;
      end
   end

   assign change = (mode_sync != cur_mode);
   assign tick   = (tick_cnt == CNT_W'(TICK_DIV - 1));

   // Display tick; a change restarts the count so the first blink phase is full length.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)            tick_cnt <= '0;
      else if (change || tick) tick_cnt <= '0;
      else                     tick_cnt <= tick_cnt + CNT_W'(1);
   end

   // Sequencer. A change takes priority over everything, including a same-cycle tick.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_BLINK;
         cur_mode <= '0;
         phase    <= '0;
         offset   <= '0;
         pass     <= '0;
         busy     <= 1'b0;
      end else if (change) begin
         state    <= ST_BLINK;
         cur_mode <= mode_sync;
         phase    <= '0;
         offset   <= '0;
         pass     <= '0;
         busy     <= 1'b1;
      end else begin
         case (state)
            ST_BLINK: begin
               busy <= 1'b1;
               if (tick) begin
                  if (phase == PH_W'(BLINK_PHASES - 1)) begin
                     state  <= ST_SCROLL;
                     phase  <= '0;
                     offset <= '0;
                     pass   <= '0;
                  end else begin
                     phase <= phase + PH_W'(1);
                  end
               end
            end
            ST_SCROLL: begin
               busy <= 1'b1;
               if (tick) begin
                  if (offset == OFF_W'(MSG_LEN - 1)) begin
                     offset <= '0;
                     if (pass == PASS_W'(SCROLL_PASSES - 1)) begin
                        state <= ST_HOLD;
                        pass  <= '0;
                        busy  <= 1'b0;
                     end else begin
                        pass <= pass + PASS_W'(1);
                     end
                  end else begin
                     offset <= offset + OFF_W'(1);
                  end
               end
            end
            ST_HOLD: busy <= 1'b0;
            default: begin
               state <= ST_HOLD;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Odd blink phases show nothing. Offset is zero outside SCROLL, so the window
   // start is simply 'offset' in every state.
   assign blank_now = (state == ST_BLINK) && phase[0];

   for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
      localparam int unsigned POS = NUM_DIGITS - 1 - d;  // leftmost digit shows offset+0
      int unsigned idx;
      char_t       ch;

      always_comb begin
         idx = 32'(offset) + POS;
         if (idx >= MSG_LEN) idx = idx - MSG_LEN;
         ch = blank_now ? C_BLANK : banner_char(32'(cur_mode), idx);
      end

      char_to_seg u_seg (
         .code (ch),
         .seg  (seg_next[7*d +: 7])
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) hex_seg <= '1;
      else          hex_seg <= seg_next;
   end

endmodule
